// File: rtl/song_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : song_sequencer_if
// Purpose  : Bundles the user controls, beat tick, song ROM port and the
//            voice-bank dispatch port of the song sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface song_sequencer_if #(
    parameter int NUM_VOICES = 3,
    parameter int SONG_LEN   = 32
) ();
    localparam int c_addr_w = 2 + $clog2(SONG_LEN);

    logic                  play;
    logic [1:0]            song;
    logic                  beat;
    logic [c_addr_w-1:0]   rom_addr;
    logic [15:0]           rom_dout;
    logic [5:0]            note_out;
    logic [5:0]            duration_out;
    logic [2:0]            meta_out;
    logic [NUM_VOICES-1:0] voice_load;
    logic                  busy;
    logic                  song_done;

    // Sequencer side
    modport master (
        input  play, song, beat, rom_dout,
        output rom_addr, note_out, duration_out, meta_out, voice_load,
               busy, song_done
    );

    // Controls, ROM and voice bank side
    modport slave (
        output play, song, beat, rom_dout,
        input  rom_addr, note_out, duration_out, meta_out, voice_load,
               busy, song_done
    );
endinterface
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : song_sequencer
// Purpose  : Walks one song of the song ROM, splits entries into chord groups,
//            dispatches notes to the voices and holds each group for its
//            duration in beat ticks.
// Revision : 1.0 - initial release
// ============================================================================
module song_sequencer #(
    parameter int NUM_VOICES = 3,
    parameter int SONG_LEN   = 32
) (
    input  logic             clk,
    input  logic             reset,
    song_sequencer_if.master bus
);
    localparam int c_idx_w = $clog2(SONG_LEN);
    localparam int c_vp_w  = $clog2(NUM_VOICES + 1);
    localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(SONG_LEN - 1);
    localparam logic [c_idx_w-1:0] c_idx_one    = c_idx_w'(1);
    localparam logic [c_vp_w-1:0]  c_num_voices = c_vp_w'(NUM_VOICES);
    localparam logic [c_vp_w-1:0]  c_vp_one     = c_vp_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_WAIT_DUR = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t                r_state, w_state_d;
    logic [1:0]            r_song_q, w_song_d;
    logic [c_idx_w-1:0]    r_idx, w_idx_d;
    logic [c_vp_w-1:0]     r_vp, w_vp_d;
    logic [5:0]            r_dur_cnt, w_dur_d;
    logic                  r_play_q;
    logic [c_idx_w+1:0]    r_rom_addr;
    logic [5:0]            r_note, r_duration;
    logic [2:0]            r_meta;
    logic [NUM_VOICES-1:0] r_voice_load;
    logic                  r_song_done, w_song_done_d;
    logic                  w_load;

    // ROM word fields
    logic       w_adv;
    logic [5:0] w_note, w_dur;
    logic [2:0] w_meta;
    logic       w_last;

    assign w_adv  = bus.rom_dout[15];
    assign w_note = bus.rom_dout[14:9];
    assign w_dur  = bus.rom_dout[8:3];
    assign w_meta = bus.rom_dout[2:0];
    assign w_last = (r_idx == c_last_idx);

    // Next-state logic: song change first, then start/pause, then per-state flow
    always_comb begin
        w_state_d     = r_state;
        w_song_d      = r_song_q;
        w_idx_d       = r_idx;
        w_vp_d        = r_vp;
        w_dur_d       = r_dur_cnt;
        w_load        = 1'b0;
        w_song_done_d = 1'b0;
        if (r_state != ST_IDLE && bus.song != r_song_q) begin
            // Restart on the newly selected song, even while paused
            w_song_d  = bus.song;
            w_idx_d   = '0;
            w_vp_d    = '0;
            w_state_d = ST_FETCH;
        end else if (r_state == ST_IDLE) begin
            if (bus.play && !r_play_q) begin
                w_song_d  = bus.song;
                w_idx_d   = '0;
                w_vp_d    = '0;
                w_state_d = ST_FETCH;
            end
        end else if (bus.play) begin
            case (r_state)
                ST_FETCH: w_state_d = ST_DISPATCH;
                ST_DISPATCH: begin
                    // Notes beyond the last voice are dropped; vp saturates
                    if (w_note != 6'd0 && r_vp < c_num_voices) begin
                        w_load = 1'b1;
                        w_vp_d = r_vp + c_vp_one;
                    end
                    if (w_adv || w_last) begin
                        w_dur_d   = w_adv ? w_dur : 6'd0;
                        w_state_d = ST_WAIT_DUR;
                    end else begin
                        w_idx_d   = r_idx + c_idx_one;
                        w_state_d = ST_FETCH;
                    end
                end
                ST_WAIT_DUR: begin
                    if (r_dur_cnt == 6'd0) begin
                        w_vp_d = '0;
                        if (w_last) begin
                            w_state_d = ST_DONE;
                        end else begin
                            w_idx_d   = r_idx + c_idx_one;
                            w_state_d = ST_FETCH;
                        end
                    end else if (bus.beat) begin
                        w_dur_d = r_dur_cnt - 6'd1;
                    end
                end
                ST_DONE: begin
                    w_song_done_d = 1'b1;
                    w_idx_d       = '0;
                    w_state_d     = ST_IDLE;
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_song_q     <= '0;
            r_idx        <= '0;
            r_vp         <= '0;
            r_dur_cnt    <= '0;
            r_play_q     <= 1'b0;
            r_rom_addr   <= '0;
            r_note       <= '0;
            r_duration   <= '0;
            r_meta       <= '0;
            r_voice_load <= '0;
            r_song_done  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_song_q     <= w_song_d;
            r_idx        <= w_idx_d;
            r_vp         <= w_vp_d;
            r_dur_cnt    <= w_dur_d;
            r_play_q     <= bus.play;
            r_song_done  <= w_song_done_d;
            r_voice_load <= w_load ? (NUM_VOICES'(1) << r_vp) : '0;
            if (w_load) begin
                r_note     <= w_note;
                r_duration <= w_dur;
                r_meta     <= w_meta;
            end
            // Address changes only on the edge entering FETCH
            if (w_state_d == ST_FETCH) begin
                r_rom_addr <= {w_song_d, w_idx_d};
            end
        end
    end

    assign bus.rom_addr     = r_rom_addr;
    assign bus.note_out     = r_note;
    assign bus.duration_out = r_duration;
    assign bus.meta_out     = r_meta;
    assign bus.voice_load   = r_voice_load;
    assign bus.song_done    = r_song_done;
    assign bus.busy         = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: doc/song_sequencer.md
# song_sequencer

Playback controller that sequences `song_rom`: it walks one 32-entry song, splits entries into chord groups, and dispatches notes to the note-player voices. It holds each group for the encoded duration, counted in beat ticks. The block sits between the user controls (play/song select), the beat generator, `song_rom` and the voice bank. The ROM word format is {advance[15], note[14:9], duration[8:3], meta[2:0]}. The ROM has one cycle of registered read latency.

## Interface
- `NUM_VOICES`, 3 — number of note-player voices; `voice_load` width.
- `SONG_LEN`, 32 — entries per song; the song index is log2(SONG_LEN) = 5 bits.
- `clk` in 1 — system clock.
- `reset` in 1 — synchronous, active-high reset.
- `play` in 1 — level signal. A rising edge starts playback; low pauses playback.
- `song` in 2 — song select; the song base address is song*SONG_LEN.
- `beat` in 1 — one-cycle beat tick.
- `rom_addr` out 7 — registered, equals {song_q, idx}.
- `rom_dout` in 16 — ROM data, valid the cycle after `rom_addr` has been stable for one edge.
- `note_out` out 6, `duration_out` out 6, `meta_out` out 3 — registered fields of the dispatched entry.
- `voice_load` out NUM_VOICES — one-hot, one-cycle load strobe qualifying `note_out`/`duration_out`/`meta_out`.
- `busy` out 1 — high in every state except IDLE.
- `song_done` out 1 — one-cycle pulse after the last group of a song completes.

## Operation
- **States:** IDLE, FETCH, DISPATCH, WAIT_DUR, DONE.
- **IDLE:**
  - On `play` rising edge (`play` && !`play_q`): latch `song_q` <= `song`, set idx <= 0, set voice pointer vp <= 0, go to FETCH.
- **FETCH:** hold `rom_addr`; go to DISPATCH.
- **DISPATCH:** sample `rom_dout`.
  - If note != 0 and vp < NUM_VOICES: set `voice_load`[vp] for the next cycle, drive the fields, and increment vp.
  - If note != 0 and vp == NUM_VOICES: drop the note silently; vp saturates.
  - If note == 0 (rest): dispatch nothing.
  - If advance == 1 or idx == SONG_LEN-1: load dur_cnt <= (advance ? duration : 0) and go to WAIT_DUR.
  - Otherwise: idx <= idx+1 and go to FETCH.
- **WAIT_DUR:**
  - If dur_cnt == 0: vp <= 0.
    - If idx == SONG_LEN-1: go to DONE.
    - Otherwise: idx <= idx+1 and go to FETCH.
  - Else, on `beat` with `play` high: dur_cnt <= dur_cnt-1.
- **DONE:** pulse `song_done`, set idx <= 0, go to IDLE.
- **Duration:** a duration of d holds the group for exactly d beat ticks. Duration 0 advances without waiting.
- **Pause:** `play` low in any non-IDLE state freezes the FSM, idx, vp and dur_cnt. `beat` ticks are ignored, not queued. `voice_load` stays 0. Releasing `play` resumes from the same state.
- **Song change while busy:** if `song` != `song_q` in any non-IDLE state, the next cycle sets `song_q` <= `song`, idx <= 0, vp <= 0, and goes to FETCH.
  - No `song_done` is generated.
  - This takes priority over all other transitions, including pause.
- **Arithmetic:** idx is a 5-bit counter and never wraps mid-song; the end of song is detected at idx == SONG_LEN-1. dur_cnt is 6-bit and never underflows.

## Timing
- **Reset:** all outputs are 0 and the FSM enters IDLE. `song_q`, idx, vp, dur_cnt and `play_q` reset to 0.
- **Start latency:** from the `play` rising-edge cycle, FETCH begins 1 cycle later and the first `voice_load` appears 3 cycles after the edge.
- **Throughput:** 2 cycles per non-advancing entry. Each group costs 2 cycles per entry, plus 1 WAIT_DUR cycle, plus the beats to count down.
- `rom_addr` updates on the edge entering FETCH and is constant through DISPATCH.
- **Simultaneous events:**
  - `reset` wins over everything.
  - A song change wins over `beat` and pause.
  - A `beat` in the same cycle dur_cnt reaches 0 is not counted toward the next group.

## Test plan
- **Song 0 start:** reset, `song`=0, `play` rising.
  - Required: `voice_load`=001 with `note_out`=49, then `voice_load`=010 with `note_out`=1 and `duration_out`=12.
  - Then 12 beat ticks elapse before `rom_addr`=2.
- **Song 1 rest group:** `song`=1.
  - Required: first group loads voice0=32 and voice1=27. The rest entry at address 34 loads nothing and holds 12 beats. The next fetch is `rom_addr`=35.
- **Voice overflow:** song 2, group at addresses 64-67 (3 notes + rest) with NUM_VOICES=2.
  - Required: only notes 32 and 27 are loaded; note 44 is dropped; vp resets for the group at 68.
- **Pause:** drop `play` mid-WAIT_DUR after 5 of 12 beats and send 10 beats, then raise `play`.
  - Required: exactly 7 further beats are needed to advance, and no `voice_load` occurs while paused.
- **Song change:** switch `song` 0→3 at idx 9.
  - Required: the next `rom_addr` is 96, there is no `song_done`, and the first load is note 32 with `meta_out`=3'b101.
- **Completion:** play song 3 to the end with continuous beats.
  - Required: one `song_done` pulse after the group at address 127 expires; `busy` falls; `play` held high does not restart until a new rising edge.
